// File: rtl/multi_array_loader.sv
// rtl/multi_array_loader.sv - loads NUM_ARRAYS on-chip arrays in sequence from a 64-bit host stream
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   reload       pulse; restarts loading from array 0 (honoured only when all arrays are loaded)
//   data         64-bit stream beat (length header or packed array words)
//   data_ready   beat valid
//   data_wanted  loader accepts a beat this cycle (registered)
//   we           one-hot write enable, one bit per array (registered)
//   waddr        shared write address (registered)
//   wdata        shared write data (registered)
//   loaded       per-array completion flags
//   all_loaded   every array has been loaded
//   overflow     sticky: header of array i exceeded the array depth
module multi_array_loader #(
  parameter int NUM_ARRAYS = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_SIZE  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reload,
  input  logic [63:0]           data,
  input  logic                  data_ready,
  output logic                  data_wanted,
  output logic [NUM_ARRAYS-1:0] we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [WORD_SIZE-1:0]  wdata,
  output logic [NUM_ARRAYS-1:0] loaded,
  output logic                  all_loaded,
  output logic [NUM_ARRAYS-1:0] overflow
);

  localparam int          WPB   = 64 / WORD_SIZE;
  localparam int          IDXW  = (NUM_ARRAYS > 1) ? $clog2(NUM_ARRAYS) : 1;
  localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;

  localparam logic [1:0] S_HEADER = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [31:0]           count_q, count_d;   // words of the current array not yet emitted
  logic [31:0]           n_q, n_d;           // index of the next word to emit
  logic [63:0]           buf_q, buf_d;       // unpacking buffer, next word in the low slice
  logic [3:0]            cnt_q, cnt_d;       // valid words in buf_q
  logic [NUM_ARRAYS-1:0] we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic [NUM_ARRAYS-1:0] loaded_q, loaded_d;
  logic [NUM_ARRAYS-1:0] ovf_q, ovf_d;
  logic                  dw_q, dw_d;

  logic                  xfer;
  logic                  last_idx;
  logic [31:0]           unbuffered;
  logic [3:0]            take;
  logic [NUM_ARRAYS-1:0] idx_onehot;
  logic                  emit;
  logic [WORD_SIZE-1:0]  emit_word;

  assign xfer       = data_ready && dw_q;
  assign last_idx   = (idx_q == IDXW'(NUM_ARRAYS - 1));
  assign idx_onehot = NUM_ARRAYS'(1) << idx_q;
  // Words still owed by the stream; a partial final beat only contributes this many.
  assign unbuffered = count_q - {28'd0, cnt_q};
  assign take       = (unbuffered >= 32'(WPB)) ? 4'(WPB) : unbuffered[3:0];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    n_d       = n_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    we_d      = '0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    loaded_d  = loaded_q;
    ovf_d     = ovf_q;
    emit      = 1'b0;
    emit_word = '0;

    case (state_q)
      S_HEADER: begin
        if (xfer) begin
          count_d = data[31:0];
          n_d     = 32'd0;
          cnt_d   = 4'd0;
          if ({1'b0, data[31:0]} > DEPTH) begin
            ovf_d = ovf_q | idx_onehot;
          end
          if (data[31:0] == 32'd0) begin
            loaded_d = loaded_q | idx_onehot;
            if (last_idx) begin
              state_d = S_DONE;
            end else begin
              idx_d = idx_q + IDXW'(1);
            end
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        // A beat arriving while one buffered word remains is stored whole; the
        // buffered word goes out first. From an empty buffer the new beat's low
        // slice is emitted directly so the first write follows the accept.
        if (cnt_q != 4'd0) begin
          emit      = 1'b1;
          emit_word = buf_q[WORD_SIZE-1:0];
          buf_d     = buf_q >> WORD_SIZE;
          cnt_d     = cnt_q - 4'd1;
          if (xfer) begin
            buf_d = data;
            cnt_d = cnt_q - 4'd1 + take;
          end
        end else if (xfer) begin
          emit      = 1'b1;
          emit_word = data[WORD_SIZE-1:0];
          buf_d     = data >> WORD_SIZE;
          cnt_d     = take - 4'd1;
        end

        if (emit) begin
          n_d     = n_q + 32'd1;
          count_d = count_q - 32'd1;
          // Words beyond the array depth are consumed but never written.
          if ({1'b0, n_q} < DEPTH) begin
            we_d    = idx_onehot;
            waddr_d = n_q[ADDR_WIDTH-1:0];
            wdata_d = emit_word;
          end
          if (count_q == 32'd1) begin
            loaded_d = loaded_q | idx_onehot;
            cnt_d    = 4'd0;
            if (last_idx) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + IDXW'(1);
              state_d = S_HEADER;
            end
          end
        end
      end

      S_DONE: begin
        if (reload) begin
          loaded_d = '0;
          ovf_d    = '0;
          idx_d    = '0;
          state_d  = S_HEADER;
        end
      end

      default: begin
        state_d = S_HEADER;
      end
    endcase

    // Registered from next state so it never depends on data_ready combinationally.
    case (state_d)
      S_HEADER: dw_d = 1'b1;
      S_DATA:   dw_d = (count_d > {28'd0, cnt_d}) && (cnt_d <= 4'd1);
      default:  dw_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_HEADER;
      idx_q    <= '0;
      count_q  <= '0;
      n_q      <= '0;
      buf_q    <= '0;
      cnt_q    <= '0;
      we_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      loaded_q <= '0;
      ovf_q    <= '0;
      dw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      n_q      <= n_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      loaded_q <= loaded_d;
      ovf_q    <= ovf_d;
      dw_q     <= dw_d;
    end
  end

  assign data_wanted = dw_q;
  assign we          = we_q;
  assign waddr       = waddr_q;
  assign wdata       = wdata_q;
  assign loaded      = loaded_q;
  assign overflow    = ovf_q;
  assign all_loaded  = (state_q == S_DONE);

endmodule

// File: tb/tb_multi_array_loader.sv
// tb/tb_multi_array_loader.sv - directed self-checking bench for multi_array_loader
module tb_multi_array_loader;

  typedef struct {
    int          cyc;
    logic [1:0]  we;
    int          addr;
    logic [63:0] d;
    logic [1:0]  ld;
  } wr_t;

  logic clk;
  int   cyc;
  int   errors;
  int   checks;

  // a: NA=2 AW=10 WS=64
  logic        rst_a, rl_a, r_a, dw_a, al_a;
  logic [63:0] d_a, wd_a;
  logic [1:0]  we_a, ld_a, ov_a;
  logic [9:0]  wa_a;
  // b: NA=1 AW=10 WS=16
  logic        rst_b, rl_b, r_b, dw_b, al_b, we_b, ld_b, ov_b;
  logic [63:0] d_b;
  logic [15:0] wd_b;
  logic [9:0]  wa_b;
  // c: NA=1 AW=10 WS=32
  logic        rst_c, rl_c, r_c, dw_c, al_c, we_c, ld_c, ov_c;
  logic [63:0] d_c;
  logic [31:0] wd_c;
  logic [9:0]  wa_c;
  // o: NA=1 AW=2 WS=64
  logic        rst_o, rl_o, r_o, dw_o, al_o, we_o, ld_o, ov_o;
  logic [63:0] d_o, wd_o;
  logic [1:0]  wa_o;

  wr_t la[$];
  wr_t lb[$];
  wr_t lc[$];
  wr_t lo[$];

  multi_array_loader #(.NUM_ARRAYS(2), .ADDR_WIDTH(10), .WORD_SIZE(64)) u_a (
    .clk(clk), .reset(rst_a), .reload(rl_a), .data(d_a), .data_ready(r_a),
    .data_wanted(dw_a), .we(we_a), .waddr(wa_a), .wdata(wd_a),
    .loaded(ld_a), .all_loaded(al_a), .overflow(ov_a));

  multi_array_loader #(.NUM_ARRAYS(1), .ADDR_WIDTH(10), .WORD_SIZE(16)) u_b (
    .clk(clk), .reset(rst_b), .reload(rl_b), .data(d_b), .data_ready(r_b),
    .data_wanted(dw_b), .we(we_b), .waddr(wa_b), .wdata(wd_b),
    .loaded(ld_b), .all_loaded(al_b), .overflow(ov_b));

  multi_array_loader #(.NUM_ARRAYS(1), .ADDR_WIDTH(10), .WORD_SIZE(32)) u_c (
    .clk(clk), .reset(rst_c), .reload(rl_c), .data(d_c), .data_ready(r_c),
    .data_wanted(dw_c), .we(we_c), .waddr(wa_c), .wdata(wd_c),
    .loaded(ld_c), .all_loaded(al_c), .overflow(ov_c));

  multi_array_loader #(.NUM_ARRAYS(1), .ADDR_WIDTH(2), .WORD_SIZE(64)) u_o (
    .clk(clk), .reset(rst_o), .reload(rl_o), .data(d_o), .data_ready(r_o),
    .data_wanted(dw_o), .we(we_o), .waddr(wa_o), .wdata(wd_o),
    .loaded(ld_o), .all_loaded(al_o), .overflow(ov_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t e;
    if (|we_a) begin
      e.cyc = cyc; e.we = we_a; e.addr = int'(wa_a); e.d = wd_a; e.ld = ld_a;
      la.push_back(e);
    end
  end
  always @(negedge clk) begin
    wr_t e;
    if (we_b) begin
      e.cyc = cyc; e.we = 2'(we_b); e.addr = int'(wa_b); e.d = 64'(wd_b); e.ld = 2'(ld_b);
      lb.push_back(e);
    end
  end
  always @(negedge clk) begin
    wr_t e;
    if (we_c) begin
      e.cyc = cyc; e.we = 2'(we_c); e.addr = int'(wa_c); e.d = 64'(wd_c); e.ld = 2'(ld_c);
      lc.push_back(e);
    end
  end
  always @(negedge clk) begin
    wr_t e;
    if (we_o) begin
      e.cyc = cyc; e.we = 2'(we_o); e.addr = int'(wa_o); e.d = wd_o; e.ld = 2'(ld_o);
      lo.push_back(e);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each send starts and ends on a falling edge; data_wanted seen there is what
  // the next rising edge samples.
  task automatic send_a(input logic [63:0] v);
    int t;
    d_a = v; r_a = 1'b1; t = 0;
    while (!dw_a && t < 50) begin @(negedge clk); t++; end
    chk("a_wanted", 64'(dw_a), 64'd1);
    @(negedge clk);
  endtask

  task automatic send_b(input logic [63:0] v);
    int t;
    d_b = v; r_b = 1'b1; t = 0;
    while (!dw_b && t < 50) begin @(negedge clk); t++; end
    chk("b_wanted", 64'(dw_b), 64'd1);
    @(negedge clk);
  endtask

  task automatic send_c(input logic [63:0] v);
    int t;
    d_c = v; r_c = 1'b1; t = 0;
    while (!dw_c && t < 50) begin @(negedge clk); t++; end
    chk("c_wanted", 64'(dw_c), 64'd1);
    @(negedge clk);
  endtask

  task automatic send_o(input logic [63:0] v);
    int t;
    d_o = v; r_o = 1'b1; t = 0;
    while (!dw_o && t < 50) begin @(negedge clk); t++; end
    chk("o_wanted", 64'(dw_o), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_d [5];
    logic [1:0]  exp_we [5];
    int          exp_ad [5];
    logic [63:0] bc [3];
    int          bi;
    logic        took;

    cyc = 0; errors = 0; checks = 0;
    rst_a = 1; rl_a = 0; r_a = 0; d_a = '0;
    rst_b = 1; rl_b = 0; r_b = 0; d_b = '0;
    rst_c = 1; rl_c = 0; r_c = 0; d_c = '0;
    rst_o = 1; rl_o = 0; r_o = 0; d_o = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_we", 64'(we_a), 64'd0);
    chk("rst_waddr", 64'(wa_a), 64'd0);
    chk("rst_wdata", wd_a, 64'd0);
    chk("rst_loaded", 64'(ld_a), 64'd0);
    chk("rst_overflow", 64'(ov_a), 64'd0);
    chk("rst_all_loaded", 64'(al_a), 64'd0);
    chk("rst_wanted", 64'(dw_a), 64'd0);
    rst_a = 0; rst_b = 0; rst_c = 0; rst_o = 0;
    @(negedge clk);

    // Two arrays, headers 3 and 2, 64-bit words, ready held high
    la.delete();
    send_a(64'd3);
    send_a(64'hA0A0_0000_0000_00A0);
    send_a(64'hA1A1_0000_0000_00A1);
    send_a(64'hA2A2_0000_0000_00A2);
    send_a(64'd2);
    send_a(64'hB0B0_0000_0000_00B0);
    send_a(64'hB1B1_0000_0000_00B1);
    r_a = 0;
    chk("t1_all_loaded", 64'(al_a), 64'd1);
    chk("t1_wanted_done", 64'(dw_a), 64'd0);
    chk("t1_loaded", 64'(ld_a), 64'd3);
    repeat (2) @(negedge clk);
    exp_we = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    exp_ad = '{0, 1, 2, 0, 1};
    exp_d  = '{64'hA0A0_0000_0000_00A0, 64'hA1A1_0000_0000_00A1, 64'hA2A2_0000_0000_00A2,
               64'hB0B0_0000_0000_00B0, 64'hB1B1_0000_0000_00B1};
    chk("t1_nwrites", 64'(la.size()), 64'd5);
    if (la.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("t1_we%0d", i), 64'(la[i].we), 64'(exp_we[i]));
        chk($sformatf("t1_addr%0d", i), 64'(la[i].addr), 64'(exp_ad[i]));
        chk($sformatf("t1_data%0d", i), la[i].d, exp_d[i]);
      end
      chk("t1_gap_a01", 64'(la[1].cyc - la[0].cyc), 64'd1);
      chk("t1_gap_a12", 64'(la[2].cyc - la[1].cyc), 64'd1);
      chk("t1_gap_b01", 64'(la[4].cyc - la[3].cyc), 64'd1);
      chk("t1_loaded_mid", 64'(la[3].ld), 64'd1);
    end

    // Reload from DONE, then header 0 for array 0, header 1 for array 1
    rl_a = 1; @(negedge clk); rl_a = 0;
    chk("t2_reload_loaded", 64'(ld_a), 64'd0);
    chk("t2_reload_all", 64'(al_a), 64'd0);
    chk("t2_reload_wanted", 64'(dw_a), 64'd1);
    la.delete();
    send_a(64'hFFFF_FFFF_0000_0000);
    r_a = 0;
    chk("t2_zero_loaded", 64'(ld_a), 64'd1);
    chk("t2_zero_nowe", 64'(we_a), 64'd0);
    send_a(64'd1);
    send_a(64'hC0C0_C0C0_C0C0_C0C0);
    r_a = 0;
    repeat (2) @(negedge clk);
    chk("t2_nwrites", 64'(la.size()), 64'd1);
    if (la.size() == 1) begin
      chk("t2_we", 64'(la[0].we), 64'd2);
      chk("t2_addr", 64'(la[0].addr), 64'd0);
      chk("t2_data", la[0].d, 64'hC0C0_C0C0_C0C0_C0C0);
    end
    chk("t2_loaded", 64'(ld_a), 64'd3);
    chk("t2_all_loaded", 64'(al_a), 64'd1);

    // Reload ignored in HEADER; reset mid-array; full reload afterwards
    rl_a = 1; @(negedge clk); rl_a = 0;
    send_a(64'd0);
    r_a = 0;
    rl_a = 1; @(negedge clk); rl_a = 0;
    chk("t3_reload_hdr_ignored", 64'(ld_a), 64'd1);
    send_a(64'd2);
    send_a(64'hD0D0_D0D0_D0D0_D0D0);
    r_a = 0;
    rst_a = 1; @(negedge clk);
    chk("t3_rst_we", 64'(we_a), 64'd0);
    chk("t3_rst_waddr", 64'(wa_a), 64'd0);
    chk("t3_rst_wdata", wd_a, 64'd0);
    chk("t3_rst_loaded", 64'(ld_a), 64'd0);
    chk("t3_rst_overflow", 64'(ov_a), 64'd0);
    chk("t3_rst_all", 64'(al_a), 64'd0);
    chk("t3_rst_wanted", 64'(dw_a), 64'd0);
    rst_a = 0;
    la.delete();
    send_a(64'd1);
    send_a(64'hE0E0_0000_0000_E0E0);
    send_a(64'd1);
    send_a(64'hF0F0_0000_0000_F0F0);
    r_a = 0;
    repeat (2) @(negedge clk);
    chk("t3_nwrites", 64'(la.size()), 64'd2);
    if (la.size() == 2) begin
      chk("t3_we0", 64'(la[0].we), 64'd1);
      chk("t3_addr0", 64'(la[0].addr), 64'd0);
      chk("t3_data0", la[0].d, 64'hE0E0_0000_0000_E0E0);
      chk("t3_we1", 64'(la[1].we), 64'd2);
      chk("t3_data1", la[1].d, 64'hF0F0_0000_0000_F0F0);
    end
    chk("t3_all_loaded", 64'(al_a), 64'd1);

    // 16-bit words, header 6, partial final beat
    lb.delete();
    send_b(64'd6);
    send_b(64'h0004_0003_0002_0001);
    send_b(64'hFFFF_EEEE_0006_0005);
    r_b = 0;
    repeat (6) @(negedge clk);
    chk("t4_nwrites", 64'(lb.size()), 64'd6);
    if (lb.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("t4_addr%0d", i), 64'(lb[i].addr), 64'(i));
        chk($sformatf("t4_data%0d", i), lb[i].d, 64'(i + 1));
        chk($sformatf("t4_cyc%0d", i), 64'(lb[i].cyc - lb[0].cyc), 64'(i));
      end
    end
    chk("t4_loaded", 64'(ld_b), 64'd1);
    chk("t4_all_loaded", 64'(al_b), 64'd1);

    // 32-bit words, ready toggling every cycle
    lc.delete();
    bc = '{64'h0000_0011_0000_0010, 64'h0000_0013_0000_0012, 64'hDEAD_BEEF_0000_0014};
    send_c(64'd5);
    bi = 0;
    for (int c = 0; c < 80 && bi < 3; c++) begin
      d_c = bc[bi];
      r_c = (c % 2 == 0);
      took = r_c && dw_c;
      @(negedge clk);
      if (took) bi++;
    end
    r_c = 0;
    chk("t5_beats_taken", 64'(bi), 64'd3);
    repeat (6) @(negedge clk);
    chk("t5_nwrites", 64'(lc.size()), 64'd5);
    if (lc.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("t5_addr%0d", i), 64'(lc[i].addr), 64'(i));
        chk($sformatf("t5_data%0d", i), lc[i].d, 64'(32'h10 + i));
      end
    end
    chk("t5_loaded", 64'(ld_c), 64'd1);

    // Depth 4, header 6: overflow and discarded words
    lo.delete();
    send_o(64'd6);
    r_o = 0;
    chk("t6_overflow", 64'(ov_o), 64'd1);
    for (int i = 0; i < 5; i++) send_o(64'h6600 + 64'(i));
    r_o = 0;
    repeat (2) @(negedge clk);
    chk("t6_loaded_after5", 64'(ld_o), 64'd0);
    send_o(64'h6605);
    r_o = 0;
    chk("t6_loaded_after6", 64'(ld_o), 64'd1);
    repeat (2) @(negedge clk);
    chk("t6_nwrites", 64'(lo.size()), 64'd4);
    if (lo.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t6_addr%0d", i), 64'(lo[i].addr), 64'(i));
        chk($sformatf("t6_data%0d", i), lo[i].d, 64'h6600 + 64'(i));
      end
    end
    rl_o = 1; @(negedge clk); rl_o = 0;
    chk("t6_reload_overflow", 64'(ov_o), 64'd0);
    chk("t6_reload_loaded", 64'(ld_o), 64'd0);
    chk("t6_reload_all", 64'(al_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
